// File: rtl/parking_slot_counter.sv
`default_nettype none
// ============================================================================
// Module      : parking_slot_counter
// Description : Parking lot occupancy controller. Synchronizes the raw entry
//               and exit car sensors, detects rising edges, latches one
//               pending request per sensor, and runs a small gate FSM that
//               strobes the entry/exit barriers while keeping the free-slot
//               count as two BCD digits for the seven-segment decoders.
//
// Parameters  : CAPACITY    - total slots (1..99), reset value of free count
//               GATE_CYCLES - clock cycles a gate strobe stays high (1..255)
//
// Build macro : PARK_ALARM_EN - when defined, a refused entry raises 'alarm'
//               for GATE_CYCLES cycles (retriggerable). When undefined,
//               'alarm' is tied low and no alarm timer is built.
//
// Ports       : clk          in   system clock
//               rst_n        in   asynchronous active-low reset
//               entry_sensor in   raw car-present level at entry (async)
//               exit_sensor  in   raw car-present level at exit (async)
//               free_tens    out  BCD tens digit of free slots
//               free_ones    out  BCD ones digit of free slots
//               full         out  free count == 0
//               empty        out  free count == CAPACITY
//               entry_gate   out  entry barrier open strobe
//               exit_gate    out  exit barrier open strobe
//               deny         out  one-cycle pulse, entry refused (lot full)
//               alarm        out  refused-entry alarm (PARK_ALARM_EN only)
//
// Revision    : 1.0 - initial release
// ============================================================================
module parking_slot_counter #(
  parameter int CAPACITY    = 20,
  parameter int GATE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       entry_sensor,
  input  logic       exit_sensor,
  output logic [3:0] free_tens,
  output logic [3:0] free_ones,
  output logic       full,
  output logic       empty,
  output logic       entry_gate,
  output logic       exit_gate,
  output logic       deny,
  output logic       alarm
);

  localparam logic [3:0] c_cap_tens  = 4'(CAPACITY / 10);
  localparam logic [3:0] c_cap_ones  = 4'(CAPACITY % 10);
  localparam logic [7:0] c_gate_load = 8'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY_OPEN = 2'd1,
    EXIT_OPEN  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Sensor synchronizers: [0]=sync1, [1]=sync2, [2]=edge-detect delay flop
  // --------------------------------------------------------------------------
  logic [2:0] r_entry_sync;
  logic [2:0] r_exit_sync;
  logic       w_entry_rise;
  logic       w_exit_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entry_sync <= 3'b000;
      r_exit_sync  <= 3'b000;
    end else begin
      r_entry_sync <= {r_entry_sync[1:0], entry_sensor};
      r_exit_sync  <= {r_exit_sync[1:0], exit_sensor};
    end
  end

  assign w_entry_rise = r_entry_sync[1] & ~r_entry_sync[2];
  assign w_exit_rise  = r_exit_sync[1]  & ~r_exit_sync[2];

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_timer;
  logic [7:0] w_timer_next;
  logic       r_entry_pend;
  logic       r_exit_pend;
  logic       w_entry_clr;
  logic       w_exit_clr;
  logic [3:0] r_tens;
  logic [3:0] r_ones;
  logic [3:0] w_tens_next;
  logic [3:0] w_ones_next;
  logic       r_full;
  logic       r_empty;
  logic       w_full_next;
  logic       w_empty_next;
  logic       r_entry_gate;
  logic       r_exit_gate;
  logic       r_deny;
  logic       w_deny_next;
  logic       w_inc;
  logic       w_dec;

  // --------------------------------------------------------------------------
  // Next-state, count arithmetic and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_entry_clr  = 1'b0;
    w_exit_clr   = 1'b0;
    w_deny_next  = 1'b0;
    w_inc        = 1'b0;
    w_dec        = 1'b0;
    w_tens_next  = r_tens;
    w_ones_next  = r_ones;
    w_full_next  = r_full;
    w_empty_next = r_empty;

    case (r_state)
      IDLE: begin
        // Exit is looked at first so a full lot frees a slot before the
        // waiting entry is evaluated on the following IDLE cycle.
        if (r_exit_pend) begin
          w_exit_clr = 1'b1;
          if (!r_empty) begin
            w_state_next = EXIT_OPEN;
            w_timer_next = c_gate_load;
            w_inc        = 1'b1;
          end
        end else if (r_entry_pend) begin
          w_entry_clr = 1'b1;
          if (!r_full) begin
            w_state_next = ENTRY_OPEN;
            w_timer_next = c_gate_load;
            w_dec        = 1'b1;
          end else begin
            w_deny_next = 1'b1;
          end
        end
      end
      ENTRY_OPEN, EXIT_OPEN: begin
        if (r_timer == 8'd0) begin
          w_state_next = IDLE;
        end else begin
          w_timer_next = r_timer - 8'd1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // The FSM guards guarantee the count stays within 0..CAPACITY, so only
    // the ones-digit wrap needs handling here.
    if (w_inc) begin
      if (r_ones == 4'd9) begin
        w_ones_next = 4'd0;
        w_tens_next = r_tens + 4'd1;
      end else begin
        w_ones_next = r_ones + 4'd1;
      end
      w_full_next  = 1'b0;
      w_empty_next = ({w_tens_next, w_ones_next} == {c_cap_tens, c_cap_ones});
    end else if (w_dec) begin
      if (r_ones == 4'd0) begin
        w_ones_next = 4'd9;
        w_tens_next = r_tens - 4'd1;
      end else begin
        w_ones_next = r_ones - 4'd1;
      end
      w_empty_next = 1'b0;
      w_full_next  = ({w_tens_next, w_ones_next} == 8'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_timer      <= 8'd0;
      r_entry_pend <= 1'b0;
      r_exit_pend  <= 1'b0;
      r_tens       <= c_cap_tens;
      r_ones       <= c_cap_ones;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_entry_gate <= 1'b0;
      r_exit_gate  <= 1'b0;
      r_deny       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_timer      <= w_timer_next;
      // A fresh edge wins over a same-cycle clear: it is a new request.
      r_entry_pend <= w_entry_rise | (r_entry_pend & ~w_entry_clr);
      r_exit_pend  <= w_exit_rise  | (r_exit_pend  & ~w_exit_clr);
      r_tens       <= w_tens_next;
      r_ones       <= w_ones_next;
      r_full       <= w_full_next;
      r_empty      <= w_empty_next;
      r_entry_gate <= (w_state_next == ENTRY_OPEN);
      r_exit_gate  <= (w_state_next == EXIT_OPEN);
      r_deny       <= w_deny_next;
    end
  end

  assign free_tens  = r_tens;
  assign free_ones  = r_ones;
  assign full       = r_full;
  assign empty      = r_empty;
  assign entry_gate = r_entry_gate;
  assign exit_gate  = r_exit_gate;
  assign deny       = r_deny;

  // --------------------------------------------------------------------------
  // Refused-entry alarm
  // --------------------------------------------------------------------------
`ifdef PARK_ALARM_EN
  logic [7:0] r_alarm_timer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alarm_timer <= 8'd0;
    end else if (w_deny_next) begin
      r_alarm_timer <= 8'(GATE_CYCLES);
    end else if (r_alarm_timer != 8'd0) begin
      r_alarm_timer <= r_alarm_timer - 8'd1;
    end
  end

  assign alarm = (r_alarm_timer != 8'd0);
`else
  assign alarm = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/parking_slot_counter.md
Name: parking_slot_counter

Overview:
- Occupancy controller for the parking lot. Sits directly upstream of the per-digit seven-segment decoders.
- Watches the entry and exit car sensors, drives the entry and exit gate strobes, and keeps the free-slot count as two BCD digits. Each digit drives one decoder.
- Produces full and empty status flags.

Parameters:
- CAPACITY, 20, total slots. Legal range 1..99. Reset value of the free count.
- GATE_CYCLES, 8, number of clock cycles a gate strobe is held high. Legal range 1..255.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- entry_sensor  input  1  raw car-present at entry, asynchronous level
- exit_sensor  input  1  raw car-present at exit, asynchronous level
- free_tens  output  4  BCD tens digit of free slots, 0..9
- free_ones  output  4  BCD ones digit of free slots, 0..9
- full  output  1  free count == 0
- empty  output  1  free count == CAPACITY
- entry_gate  output  1  entry barrier open strobe
- exit_gate  output  1  exit barrier open strobe
- deny  output  1  one-cycle pulse: entry refused, lot full
- alarm  output  1  see Optional Feature

Behaviour:
- One clock, clk. Asynchronous active-low reset rst_n. All state is on rising clk edges or falling rst_n.
- Reset values:
  - free count = CAPACITY in BCD; e.g. 20 gives tens=2, ones=0.
  - full=0; empty=1; entry_gate=0; exit_gate=0; deny=0; alarm=0.
  - FSM=IDLE; pending flags=0; synchronizers=0.
- Sensor input path, per sensor:
  - Two-flop synchronizer, then a third flop for edge detection.
  - Rising edge = sync2 & ~sync3. A level held high counts once.
  - The edge sets a pending flag (entry_pend / exit_pend) on the next edge.
  - A flag that is already set absorbs further edges; no queue depth beyond 1.
- FSM states: IDLE, ENTRY_OPEN, EXIT_OPEN. The gate timer is 8 bits.
- In IDLE, evaluated each edge:
  - exit_pend=1 and not empty:
    - go to EXIT_OPEN; clear exit_pend.
    - free count +1 on this same edge.
    - timer = GATE_CYCLES-1.
  - exit_pend=1 and empty: clear exit_pend, no action (spurious exit).
  - Otherwise, entry_pend=1 and not full:
    - go to ENTRY_OPEN; clear entry_pend.
    - free count -1 on this same edge.
    - timer loaded as above.
  - Otherwise, entry_pend=1 and full: clear entry_pend; deny=1 for exactly one cycle; stay IDLE.
  - Exit has priority over entry when both flags are pending. The freed slot is then available to the entry on the next IDLE evaluation.
- ENTRY_OPEN / EXIT_OPEN:
  - The matching gate output is high for exactly GATE_CYCLES cycles.
  - The timer decrements; when it reaches 0, return to IDLE and drop the gate.
  - Pending flags keep latching while a gate is open and are serviced on return to IDLE.
  - There is at least one IDLE cycle between consecutive gate strobes.
- Latency, with idle FSM and no other pending request:
  - The first clk edge sampling the sensor high counts as edge 1.
  - Gate output rises after edge 4. The count changes on edge 4.
- BCD arithmetic:
  - The count is held directly as two BCD digits.
  - Increment: ones 9→0 with tens+1.
  - Decrement: ones 0→9 with tens-1.
  - Never exceeds CAPACITY and never goes below 0; the guards above enforce this.
  - Digits are never outside 0..9.
- full and empty are registered and update on the same edge as the count.
- Reset asserted mid-operation: immediately returns every output and state to its reset value. Gates drop asynchronously, and the count reloads to CAPACITY.

Optional Feature:
- Macro name: PARK_ALARM_EN.
- When defined:
  - A deny event loads a separate alarm timer with GATE_CYCLES.
  - alarm is high while that timer is nonzero.
  - A new deny during an active alarm reloads the timer.
- When undefined: alarm is tied to 0 and the alarm timer logic is not built.

Test Plan:
- Reset with CAPACITY=3: free_tens=0, free_ones=3, empty=1, full=0, all gates 0. Assert rst_n low mid-strobe → gate drops without waiting for clk.
- GATE_CYCLES=4, one entry pulse held 10 cycles → entry_gate high for exactly 4 cycles, starting after edge 4. free_ones 3→2; empty→0; only one entry counted.
- 3 entries, then a 4th → free=0 and full=1. The 4th produces deny for 1 cycle, no entry_gate, and the count stays 0. With PARK_ALARM_EN, alarm is high for 4 cycles.
- Full lot, entry and exit rising on the same cycle → exit_gate strobes first and free goes 0→1. Then entry_gate strobes and free goes 1→0. No deny.
- CAPACITY=20, 11 entries → digits step 20,19,…,10,09. Then 1 exit → 10. Checks BCD borrow and carry.
- Empty lot with an exit pulse → no exit_gate, count stays CAPACITY, empty stays 1.
